// File: rtl/filter_frame_sequencer.sv
// Frame-aware pass-through stage between the camera stream and the filter bank.
// Re-aligns on sop, checks frame length, and commits filter mode changes only on sop beats.
module filter_frame_sequencer #(
    parameter int DATA_W       = 12,
    parameter int FRAME_PIXELS = 76800,
    parameter int HOLD_FRAMES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        freq_flag,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sop_in,
    input  logic              eop_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              eop_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [1:0]        filter_sel,
    output logic              frame_active,
    output logic              frame_err
);

    localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // Valid/ready: a beat moves on either side only on a clock edge where
    // valid and ready are both high; the output register holds otherwise.
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [1:0]          cand_q, cand_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                accept;
    logic                forward;

    assign ready_out = ready_in || !valid_q;
    assign accept    = valid_in && ready_out;
    assign forward   = accept && (sop_in || (state_q == IN_FRAME));

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        cand_d    = cand_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        valid_d   = valid_q;
        err_d     = 1'b0;

        if (ready_out) begin
            valid_d = forward;
            sop_d   = forward && sop_in;
            eop_d   = forward && eop_in;
        end
        if (forward) begin
            data_d = data_in;
        end

        if (accept) begin
            if (sop_in) begin
                pix_cnt_d = CNT_W'(1);
                state_d   = eop_in ? WAIT_SOP : IN_FRAME;
            end else if (state_q == IN_FRAME) begin
                if (pix_cnt_q != {CNT_W{1'b1}}) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (eop_in) begin
                    state_d = WAIT_SOP;
                end
            end
            // A sop inside a frame restarts the frame but is still an error.
            err_d = (sop_in && (state_q == IN_FRAME)) ||
                    (forward && eop_in && (pix_cnt_d != CNT_W'(FRAME_PIXELS)));
        end

        // Mode request must repeat on HOLD_FRAMES consecutive sop beats.
        if (accept && sop_in) begin
            if (freq_flag == cand_q) begin
                if (hold_q < HOLD_W'(HOLD_FRAMES)) begin
                    hold_d = hold_q + 1'b1;
                end
            end else begin
                cand_d = freq_flag;
                hold_d = HOLD_W'(1);
            end
            if (hold_d >= HOLD_W'(HOLD_FRAMES)) begin
                sel_d = cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_SOP;
            pix_cnt_q <= '0;
            cand_q    <= '0;
            hold_q    <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            cand_q    <= cand_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign data_out     = data_q;
    assign sop_out      = sop_q;
    assign eop_out      = eop_q;
    assign valid_out    = valid_q;
    assign filter_sel   = sel_q;
    assign frame_active = (state_q == IN_FRAME);
    assign frame_err    = err_q;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer with FRAME_PIXELS=4, HOLD_FRAMES=2.
// Expected values are hand-computed per step; the backpressure phase uses an expected queue.
module tb_filter_frame_sequencer;

    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        freq_flag = 2'd0;
    logic [DATA_W-1:0] data_in = '0;
    logic              sop_in = 1'b0;
    logic              eop_in = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              sop_out;
    logic              eop_out;
    logic              valid_out;
    logic              ready_in = 1'b1;
    logic [1:0]        filter_sel;
    logic              frame_active;
    logic              frame_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    filter_frame_sequencer #(
        .DATA_W(DATA_W),
        .FRAME_PIXELS(4),
        .HOLD_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .freq_flag(freq_flag),
        .data_in(data_in),
        .sop_in(sop_in),
        .eop_in(eop_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .data_out(data_out),
        .sop_out(sop_out),
        .eop_out(eop_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .filter_sel(filter_sel),
        .frame_active(frame_active),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [11:0] d, input logic s, input logic e, input logic [1:0] f);
        @(negedge clk);
        data_in   = d;
        sop_in    = s;
        eop_in    = e;
        freq_flag = f;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_sel", 32'(filter_sel), 32'h0);
        chk("rst_active", 32'(frame_active), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [11:0] base, input logic [1:0] sop_flag,
                              input logic [1:0] other_flag, input logic [1:0] exp_sel);
        for (int i = 0; i < 4; i++) begin
            beat(12'(base + 12'(i)), i == 0, i == 3, (i == 0) ? sop_flag : other_flag);
            chk("frm_data", 32'(data_out), 32'(12'(base + 12'(i))));
            chk("frm_valid", 32'(valid_out), 32'h1);
            chk("frm_sop", 32'(sop_out), 32'(i == 0));
            chk("frm_eop", 32'(eop_out), 32'(i == 3));
            chk("frm_sel", 32'(filter_sel), 32'(exp_sel));
            chk("frm_err", 32'(frame_err), 32'h0);
            chk("frm_active", 32'(frame_active), 32'(i != 3));
        end
    endtask

    initial begin
        logic [1:0]  flag_tab [5];
        logic [1:0]  sel_tab [5];
        logic [11:0] hold_data;
        logic [15:0] got;
        logic        held;
        int          idx;
        int          cyc;

        // Reset values while reset is held low.
        #2;
        chk("init_valid", 32'(valid_out), 32'h0);
        chk("init_sop", 32'(sop_out), 32'h0);
        chk("init_eop", 32'(eop_out), 32'h0);
        chk("init_data", 32'(data_out), 32'h0);
        chk("init_sel", 32'(filter_sel), 32'h0);
        chk("init_active", 32'(frame_active), 32'h0);
        chk("init_err", 32'(frame_err), 32'h0);
        chk("init_ready", 32'(ready_out), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Three frames with a steady request of 2: commit on the second sop.
        send_frame(12'h100, 2'd2, 2'd2, 2'd0);
        send_frame(12'h110, 2'd2, 2'd2, 2'd2);
        send_frame(12'h120, 2'd2, 2'd2, 2'd2);
        idle();
        chk("t1_idle_valid", 32'(valid_out), 32'h0);

        // Alternating requests never commit; mid-frame flag changes are ignored.
        rst_pulse();
        send_frame(12'h200, 2'd2, 2'd2, 2'd0);
        send_frame(12'h210, 2'd3, 2'd3, 2'd0);
        send_frame(12'h220, 2'd2, 2'd2, 2'd0);
        send_frame(12'h230, 2'd2, 2'd1, 2'd2);
        send_frame(12'h240, 2'd1, 2'd1, 2'd2);
        idle();

        // Beats before the first sop after reset are dropped.
        rst_pulse();
        beat(12'h123, 1'b0, 1'b0, 2'd0);
        chk("t3_drop1_valid", 32'(valid_out), 32'h0);
        chk("t3_drop1_ready", 32'(ready_out), 32'h1);
        beat(12'h456, 1'b0, 1'b0, 2'd0);
        chk("t3_drop2_valid", 32'(valid_out), 32'h0);
        chk("t3_drop2_ready", 32'(ready_out), 32'h1);
        send_frame(12'hABC, 2'd0, 2'd0, 2'd0);

        // Short frame, then a sop arriving inside a frame.
        beat(12'h700, 1'b1, 1'b0, 2'd0);
        chk("t4_sop_err", 32'(frame_err), 32'h0);
        beat(12'h701, 1'b0, 1'b0, 2'd0);
        chk("t4_mid_err", 32'(frame_err), 32'h0);
        beat(12'h702, 1'b0, 1'b1, 2'd0);
        chk("t4_short_err", 32'(frame_err), 32'h1);
        chk("t4_short_eop", 32'(eop_out), 32'h1);
        idle();
        chk("t4_err_clear", 32'(frame_err), 32'h0);
        beat(12'h710, 1'b1, 1'b0, 2'd0);
        beat(12'h711, 1'b0, 1'b0, 2'd0);
        chk("t4_pre_err", 32'(frame_err), 32'h0);
        beat(12'h712, 1'b1, 1'b0, 2'd0);
        chk("t4_resop_err", 32'(frame_err), 32'h1);
        chk("t4_resop_sop", 32'(sop_out), 32'h1);
        chk("t4_resop_data", 32'(data_out), 32'h712);
        chk("t4_resop_active", 32'(frame_active), 32'h1);
        beat(12'h713, 1'b0, 1'b0, 2'd0);
        chk("t4_after_err", 32'(frame_err), 32'h0);
        beat(12'h714, 1'b0, 1'b0, 2'd0);
        beat(12'h715, 1'b0, 1'b1, 2'd0);
        chk("t4_recount_err", 32'(frame_err), 32'h0);
        chk("t4_recount_eop", 32'(eop_out), 32'h1);
        idle();

        // Random downstream backpressure over five frames.
        rst_pulse();
        flag_tab = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        sel_tab  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        hold_data = '0;
        while ((idx < 20 || exp_q.size() != 0) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk("t5_stall_hold", 32'({valid_out, data_out}), 32'({1'b1, hold_data}));
            end
            chk("t5_err", 32'(frame_err), 32'h0);
            ready_in = ($urandom_range(0, 3) != 0);
            if (idx < 20) begin
                valid_in  = 1'b1;
                data_in   = 12'(12'h500 + 12'(idx));
                sop_in    = (idx % 4 == 0);
                eop_in    = (idx % 4 == 3);
                freq_flag = flag_tab[idx / 4];
            end else begin
                valid_in = 1'b0;
                sop_in   = 1'b0;
                eop_in   = 1'b0;
            end
            #1;
            held      = valid_out && !ready_in;
            hold_data = data_out;
            if (valid_out && ready_in) begin
                chk("t5_expected_beat", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk("t5_beat", 32'({filter_sel, sop_out, eop_out, data_out}), 32'(got));
                end
            end
            if (valid_in && ready_out) begin
                exp_q.push_back({sel_tab[idx / 4], sop_in, eop_in, data_in});
                idx++;
            end
        end
        chk("t5_drained", 32'(exp_q.size() + (20 - idx)), 32'h0);
        @(negedge clk);
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame.
        beat(12'h600, 1'b1, 1'b0, 2'd3);
        chk("t6_pre_sel", 32'(filter_sel), 32'h3);
        chk("t6_pre_sop", 32'(sop_out), 32'h1);
        @(negedge clk);
        data_in = 12'h601;
        sop_in  = 1'b0;
        reset   = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid_out), 32'h0);
        chk("t6_rst_sop", 32'(sop_out), 32'h0);
        chk("t6_rst_data", 32'(data_out), 32'h0);
        chk("t6_rst_sel", 32'(filter_sel), 32'h0);
        chk("t6_rst_active", 32'(frame_active), 32'h0);
        chk("t6_rst_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        beat(12'h602, 1'b0, 1'b0, 2'd3);
        chk("t6_drop_a", 32'(valid_out), 32'h0);
        beat(12'h603, 1'b0, 1'b1, 2'd3);
        chk("t6_drop_b", 32'(valid_out), 32'h0);
        chk("t6_drop_err", 32'(frame_err), 32'h0);
        send_frame(12'h610, 2'd3, 2'd3, 2'd0);
        send_frame(12'h620, 2'd3, 2'd3, 2'd3);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/filter_frame_sequencer.md
# filter_frame_sequencer

Frame-aware controller that sits between the camera stream source and the pixel filter bank. It passes 12-bit RGB444 pixels through one registered Avalon-ST stage. It owns the filter-select control: a requested `freq_flag` must be stable for `HOLD_FRAMES` consecutive frame starts before it is committed, and a committed change only ever takes effect on a start-of-packet beat. It also resynchronises on the first `sop` after reset or loss of framing, and flags frames whose length differs from `FRAME_PIXELS`.

## Interface
- `DATA_W`, 12, pixel width (RGB444).
- `FRAME_PIXELS`, 76800, expected beats per frame, `sop` and `eop` beats included.
- `HOLD_FRAMES`, 2, consecutive frame starts with an identical request required before commit; minimum 1.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `freq_flag`  in  2  requested filter mode; sampled only on accepted `sop` beats.
- `data_in`  in  DATA_W  sink pixel.
- `sop_in`  in  1  sink start of packet.
- `eop_in`  in  1  sink end of packet.
- `valid_in`  in  1  sink valid.
- `ready_out`  out  1  backpressure to upstream.
- `data_out`  out  DATA_W  source pixel, registered.
- `sop_out`  out  1  source start of packet, registered.
- `eop_out`  out  1  source end of packet, registered.
- `valid_out`  out  1  source valid, registered.
- `ready_in`  in  1  backpressure from downstream.
- `filter_sel`  out  2  committed mode; drives the filter bank's mode input.
- `frame_active`  out  1  high while in IN_FRAME.
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- Handshake:
  - `ready_out = ready_in || !valid_out` (combinational).
  - A beat is accepted when `valid_in && ready_out`.
  - The output register (`data_out`, `sop_out`, `eop_out`, `valid_out`) loads only when `ready_out` is high.
  - With no accepted beat on a load, `valid_out` loads 0.
- States:
  - WAIT_SOP (reset state): accepted beats without `sop_in` are consumed and dropped (`valid_out` loads 0). An accepted beat with `sop_in` is forwarded and the FSM moves to IN_FRAME, or stays in WAIT_SOP if `eop_in` is also high.
  - IN_FRAME: every accepted beat is forwarded. An accepted beat with `eop_in` returns the FSM to WAIT_SOP.
- Pixel counter (width `$clog2(FRAME_PIXELS+1)`):
  - Set to 1 on an accepted `sop` beat.
  - Otherwise incremented on each accepted IN_FRAME beat, saturating at all-ones.
- `frame_err` pulses in two cases:
  - An accepted `eop` beat whose post-update count is not equal to `FRAME_PIXELS`.
  - An accepted `sop_in` while in IN_FRAME. That beat is treated as a new frame start: it is forwarded, the counter is set to 1, the FSM stays in IN_FRAME, and mode logic runs as normal.
- Mode commit logic, evaluated on every accepted `sop` beat:
  - If `freq_flag == cand`: `cnt = min(cnt+1, HOLD_FRAMES)`.
  - Otherwise: `cand = freq_flag`, `cnt = 1`.
  - If the new `cnt >= HOLD_FRAMES`: `filter_sel <= new cand`.
- `freq_flag` is ignored on all non-`sop` beats; `filter_sel` is constant between `sop` beats.
- `frame_active` is high in IN_FRAME only.

## Timing
- Reset values (asynchronous, while `reset` = 0):
  - `valid_out`, `sop_out`, `eop_out`, `frame_active`, `frame_err` = 0.
  - `data_out` = 0, `filter_sel` = 0.
  - `cand` = 0, `cnt` = 0, counter = 0, FSM = WAIT_SOP.
- `ready_out` is 1 in reset when `ready_in` = 1.
- Latency: one cycle from acceptance to `valid_out`. Throughput is one beat per cycle while `ready_in` = 1.
- `filter_sel` updates on the same edge that loads the `sop` beat into the output register, so the new mode is aligned with `sop_out`.
- `frame_err` is asserted on the edge after the offending beat is accepted, for exactly one cycle.
- Stall (`ready_in` = 0 with `valid_out` = 1):
  - Outputs hold, `ready_out` = 0, and no state changes.
  - `freq_flag` changes during the stall have no effect.
- Reset mid-frame: outputs clear immediately and the partial frame is abandoned. After release, beats are dropped until the next `sop_in`. `filter_sel` returns to 0 and a new mode needs `HOLD_FRAMES` `sop` beats.
- A beat with both `sop_in` and `eop_in` is a 1-beat frame. It is evaluated as a `sop` beat for mode logic, and `frame_err` pulses unless `FRAME_PIXELS` = 1.

## Test plan
- `FRAME_PIXELS`=4, `HOLD_FRAMES`=2; reset, then send 3 frames of 4 beats with `freq_flag`=2 and `ready_in`=1 -> `filter_sel`=0 on frame 1 and 2 on frames 2–3, changing on the cycle `sop_out`=1; `frame_err` never pulses.
- `freq_flag` alternating 2,3,2 across consecutive `sop` beats -> `filter_sel` stays 0; `freq_flag` changing mid-frame -> no `filter_sel` change.
- Send beats 0x123, 0x456 without `sop` after reset, then a 4-beat frame starting 0xABC -> first two beats dropped (`valid_out`=0, `ready_out`=1); `data_out` sequence starts 0xABC.
- 3-beat frame with `eop` on beat 3 -> `frame_err` pulses once; `sop` on beat 3 of a frame -> `frame_err` pulse, beat forwarded with `sop_out`=1, next frame counted from 1.
- Random `ready_in` toggling over 5 frames -> no beat lost or duplicated; `data_out` holds while `ready_in`=0; `filter_sel` changes only on the `sop_out` cycle.
- Assert `reset`=0 at beat 2 of a frame, release, send `sop` frame -> all outputs 0 during reset; `filter_sel`=0; next frame is forwarded from its `sop`.
